// File: rtl/sv_alu_param_pkg.sv
// Shared types and widths for the ALU stimulus receive path.
package sv_alu_param_pkg;

  localparam int unsigned OP_WIDTH = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {
    MOVI_REG = 2'b00,
    MOVI_MEM = 2'b01,
    MOVI_IMM = 2'b10,
    MOVI_ILL = 2'b11
  } movi_t;

  // Default-width view of one buffered operation
  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } alu_op_t;

endpackage

// File: rtl/alu_in_fifo.sv
// Generic synchronous show-ahead FIFO; dout always presents the head entry.
module alu_in_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/alu_in_rx.sv
// ALU stimulus responder: resolves operand B, buffers ops, drops illegal MOVI.
module alu_in_rx
  import sv_alu_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          ACT,
  output logic                          ALU_RDY,
  input  logic [OP_WIDTH-1:0]           OP,
  input  logic [1:0]                    MOVI,
  input  logic [DATA_WIDTH-1:0]         REG_A,
  input  logic [DATA_WIDTH-1:0]         REG_B,
  input  logic [DATA_WIDTH-1:0]         MEM,
  input  logic [DATA_WIDTH-1:0]         IMM,
  output logic                          EXE_VLD,
  input  logic                          EXE_RDY,
  output logic [OP_WIDTH-1:0]           EXE_OP,
  output logic [DATA_WIDTH-1:0]         EXE_A,
  output logic [DATA_WIDTH-1:0]         EXE_B,
  output logic                          ERR_ILLEGAL,
  output logic [15:0]                   DROP_CNT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int unsigned ENTRY_W = OP_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

  logic                  alu_rdy_q, alu_rdy_d;
  logic                  err_q, err_d;
  logic [15:0]           drop_q, drop_d;
  logic [DATA_WIDTH-1:0] b_sel_c;
  logic                  xfer_c;
  logic                  illegal_c;
  logic                  push_c;
  logic                  pop_c;
  logic [LVL_W-1:0]      lvl_nxt_c;
  logic [ENTRY_W-1:0]    head_c;
  logic                  fifo_full_c;
  logic                  fifo_empty_c;

  always_comb begin
    b_sel_c = REG_B;
    case (movi_t'(MOVI))
      MOVI_MEM: b_sel_c = MEM;
      MOVI_IMM: b_sel_c = IMM;
      default:  b_sel_c = REG_B;
    endcase
  end

  assign xfer_c    = ACT && alu_rdy_q;
  assign illegal_c = xfer_c && (MOVI == MOVI_ILL);
  assign push_c    = xfer_c && !illegal_c;
  assign pop_c     = !fifo_empty_c && EXE_RDY;

  // Ready is registered from the post-edge occupancy, so EXE_RDY never reaches ALU_RDY combinationally
  always_comb begin
    lvl_nxt_c = FIFO_LEVEL + LVL_W'(push_c) - LVL_W'(pop_c);
    alu_rdy_d = (lvl_nxt_c < LVL_W'(FIFO_DEPTH));
    err_d     = illegal_c;
    drop_d    = drop_q;
    if (illegal_c && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      alu_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      alu_rdy_q <= alu_rdy_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  alu_in_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   ({OP, REG_A, b_sel_c}),
    .dout  (head_c),
    .full  (fifo_full_c),
    .empty (fifo_empty_c),
    .level (FIFO_LEVEL)
  );

  assign ALU_RDY     = alu_rdy_q && !fifo_full_c;
  assign EXE_VLD     = !fifo_empty_c;
  assign EXE_OP      = head_c[ENTRY_W-1 -: OP_WIDTH];
  assign EXE_A       = head_c[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign EXE_B       = head_c[DATA_WIDTH-1:0];
  assign ERR_ILLEGAL = err_q;
  assign DROP_CNT    = drop_q;

endmodule
